// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART blocks.
//   state_t     - transmitter FSM states (PARITY is only entered when the
//                 UART_TX_PARITY_EN macro is defined)
//   LINE_IDLE   - line level between frames and during stop bits
//   START_BIT   - line level of the start bit
//   calc_div    - clocks per bit for a given clock frequency and baud rate
//   cnt_width   - width of a counter that spans 0..div-1
package uart_pkg;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Never narrower than one bit, so a degenerate divider still elaborates
  // far enough to reach the divider range check in the top.
  function automatic int cnt_width(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: valid/ready word handshake into the UART transmitter.
//   tx_data  [DATA_BITS] word to send, sampled on handshake
//   tx_valid             tx_data is valid
//   tx_ready             transmitter accepts a word this cycle
// Modports: master (word source), slave (transmitter).
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer shared by the UART TX and RX.
//   clk, nrst  clock, synchronous active-low reset
//   restart    clears the count so the next bit period starts this edge
//   bit_tick   high on the last clock (count == DIV-1) of every bit period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV = 1250
) (
  input  logic clk,
  input  logic nrst,
  input  logic restart,
  output logic bit_tick
);

  localparam int            CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Wrap is an explicit reload at DIV-1; DIV need not be a power of two.
  always_ff @(posedge clk) begin
    if (!nrst)                        cnt <= '0;
    else if (restart || cnt == LAST)  cnt <= '0;
    else                              cnt <= cnt + 1'b1;
  end

  assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits; each bit lasts DIV = CLK_FREQ/BAUD clocks.
// Optional feature macro: UART_TX_PARITY_EN (inserts a parity bit,
// sense chosen by PARITY_ODD).
//   clk, nrst  clock, synchronous active-low reset
//   bus        slave side of the tx_data/tx_valid/tx_ready handshake
//   tx         registered serial line, idle high
//   busy       high while a frame is on the line
//   bit_tick   pulse on the last clock of each bit period
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             nrst,
  uart_tx_param_if.slave   bus,
  output logic             tx,
  output logic             busy,
  output logic             bit_tick
);

  localparam int            DIV       = calc_div(CLK_FREQ, BAUD);
  localparam int            IW        = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_param: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_chk
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_par_chk
    $error("uart_tx_param: PARITY_ODD must be 0 or 1");
  end

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 tick;
  logic                 last_stop;
  logic                 accept;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif

  // The final clock of the last stop bit doubles as the accept slot for
  // the next word, which is what lets frames abut with no idle gap.
  assign last_stop    = tick && (state == STOP) && (stop_idx == LAST_STOP);
  assign bus.tx_ready = (state == IDLE) || last_stop;
  assign accept       = bus.tx_valid && bus.tx_ready;
  assign bit_tick     = tick;

  // Held in restart while idle so the start bit is phase-aligned to accept.
  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk      (clk),
    .nrst     (nrst),
    .restart  (accept || state == IDLE),
    .bit_tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      tx       <= LINE_IDLE;
      busy     <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else if (accept) begin
      state    <= START;
      tx       <= START_BIT;
      busy     <= 1'b1;
      shreg    <= bus.tx_data;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
      // Parity taken from the word as latched, before shifting destroys it.
      par_bit  <= (^bus.tx_data) ^ 1'(PARITY_ODD);
`endif
    end else if (tick) begin
      case (state)
        START: begin
          state <= DATA;
          tx    <= shreg[0];
          shreg <= shreg >> 1;
        end
        DATA: begin
          if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state <= PARITY;
            tx    <= par_bit;
`else
            state <= STOP;
            tx    <= LINE_IDLE;
`endif
          end else begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state <= STOP;
          tx    <= LINE_IDLE;
        end
`endif
        STOP: begin
          if (stop_idx == LAST_STOP) begin
            state <= IDLE;
            tx    <= LINE_IDLE;
            busy  <= 1'b0;
          end else begin
            stop_idx <= stop_idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= LINE_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed bench for uart_tx_param.
// DUT a: default parameters (DIV=1250, 8N1).
// DUT b: DIV=4, DATA_BITS=7, STOP_BITS=2, PARITY_ODD=1.
// Expected frames are hand-written line patterns, frame bit i at index i.
// Builds with or without UART_TX_PARITY_EN.
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NF = 10 + PB;   // both DUTs: 10 line bits without parity

  logic clk = 1'b0;
  logic nrst;
  logic sel;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_BITS(8)) bus_a ();
  uart_tx_param_if #(.DATA_BITS(7)) bus_b ();

  logic tx_a, busy_a, tick_a;
  logic tx_b, busy_b, tick_b;

  uart_tx_param u_a (
    .clk (clk), .nrst (nrst), .bus (bus_a),
    .tx (tx_a), .busy (busy_a), .bit_tick (tick_a)
  );

  uart_tx_param #(
    .CLK_FREQ (400), .BAUD (100), .DATA_BITS (7),
    .STOP_BITS (2), .PARITY_ODD (1)
  ) u_b (
    .clk (clk), .nrst (nrst), .bus (bus_b),
    .tx (tx_b), .busy (busy_b), .bit_tick (tick_b)
  );

  wire logic tx_s    = sel ? tx_b           : tx_a;
  wire logic busy_s  = sel ? busy_b         : busy_a;
  wire logic tick_s  = sel ? tick_b         : tick_a;
  wire logic ready_s = sel ? bus_b.tx_ready : bus_a.tx_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // 8-bit frame: start, data, [parity p], one stop
  function automatic logic [15:0] fa(input logic [7:0] d, input logic p);
    logic [15:0] r;
    r = {5'b0, 1'b1, p, d, 1'b0};
    if (PB == 0) r = {6'b0, 1'b1, d, 1'b0};
    return r;
  endfunction

  // 7-bit frame: start, data, [parity p], two stops
  function automatic logic [15:0] fb(input logic [6:0] d, input logic p);
    logic [15:0] r;
    r = {5'b0, 2'b11, p, d, 1'b0};
    if (PB == 0) r = {6'b0, 2'b11, d, 1'b0};
    return r;
  endfunction

  // Called just after the accept edge; checks every clock of the frame.
  // With noise set, tx_valid/tx_data of DUT b are scrambled every cycle
  // except the final stop clock, where valid is forced low.
  task automatic check_frame(input string tag, input logic [15:0] bits,
                             input int nf, input bit noise);
    int div = sel ? 4 : 1250;
    for (int b = 0; b < nf; b++) begin
      int         tx_bad  = 0;
      int         ctl_bad = 0;
      logic [2:0] ctl_got = '0;
      logic [2:0] ctl_exp = '0;
      for (int k = 0; k < div; k++) begin
        logic [2:0] g, e;
        @(negedge clk);
        if (tx_s !== bits[b]) tx_bad++;
        g = {busy_s, tick_s, ready_s};
        e = {1'b1, k == div - 1, (b == nf - 1) && (k == div - 1)};
        if (g !== e) begin
          if (ctl_bad == 0) begin ctl_got = g; ctl_exp = e; end
          ctl_bad++;
        end
        if (noise) begin
          bus_b.tx_valid = ((b == nf - 1) && (k == div - 1)) ? 1'b0 : 1'($urandom);
          bus_b.tx_data  = 7'($urandom);
        end
      end
      chk($sformatf("%s bit%0d tx wrong clocks", tag, b), tx_bad, 0);
      chk($sformatf("%s bit%0d busy/tick/ready (first bad %b want %b) count",
                    tag, b, ctl_got, ctl_exp), ctl_bad, 0);
    end
  endtask

  initial begin
    int bad;
    nrst = 1'b0;
    sel  = 1'b0;
    bus_a.tx_valid = 1'b0; bus_a.tx_data = '0;
    bus_b.tx_valid = 1'b0; bus_b.tx_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset a tx",    tx_a, 1);
    chk("reset a ready", bus_a.tx_ready, 1);
    chk("reset a busy",  busy_a, 0);
    chk("reset a tick",  tick_a, 0);
    chk("reset b tx",    tx_b, 1);
    chk("reset b ready", bus_b.tx_ready, 1);
    nrst = 1'b1;

    // single frame 0x54 (three ones: even parity 1)
    @(negedge clk);
    bus_a.tx_data = 8'h54; bus_a.tx_valid = 1'b1;
    @(posedge clk); #1 bus_a.tx_valid = 1'b0;
    check_frame("a54", fa(8'h54, 1'b1), NF, 1'b0);
    @(negedge clk);
    chk("a54 idle tx", tx_a, 1);
    chk("a54 idle busy", busy_a, 0);
    chk("a54 idle ready", bus_a.tx_ready, 1);

    // back-to-back 0xA5 then 0x3C, valid held high across the handoff
    @(negedge clk);
    bus_a.tx_data = 8'hA5; bus_a.tx_valid = 1'b1;
    @(posedge clk); #1 bus_a.tx_data = 8'h3C;
    check_frame("aA5", fa(8'hA5, 1'b0), NF, 1'b0);
    @(posedge clk); #1 bus_a.tx_valid = 1'b0;
    check_frame("a3C", fa(8'h3C, 1'b0), NF, 1'b0);
    @(negedge clk);
    chk("a3C idle tx", tx_a, 1);
    chk("a3C idle busy", busy_a, 0);

    // small DUT: 0x7F, 7 data bits, 2 stops (odd parity of seven ones = 0)
    sel = 1'b1;
    @(negedge clk);
    bus_b.tx_data = 7'h7F; bus_b.tx_valid = 1'b1;
    @(posedge clk); #1 bus_b.tx_valid = 1'b0;
    check_frame("b7F", fb(7'h7F, 1'b0), NF, 1'b0);
    @(negedge clk);
    chk("b7F idle tx", tx_b, 1);
    chk("b7F idle busy", busy_b, 0);

    // reset during the 4th data bit of 0x2D (bit3 = 1)
    @(negedge clk);
    bus_b.tx_data = 7'h2D; bus_b.tx_valid = 1'b1;
    @(posedge clk); #1 bus_b.tx_valid = 1'b0;
    repeat (18) @(negedge clk);
    chk("b2D 4th data bit", tx_b, 1);
    chk("b2D mid busy", busy_b, 1);
    nrst = 1'b0;
    @(negedge clk);
    chk("mid reset tx", tx_b, 1);
    chk("mid reset busy", busy_b, 0);
    chk("mid reset ready", bus_b.tx_ready, 1);
    chk("mid reset tick", tick_b, 0);
    nrst = 1'b1;

    // 0x6A after the reset (four ones: odd parity 1)
    @(negedge clk);
    bus_b.tx_data = 7'h6A; bus_b.tx_valid = 1'b1;
    @(posedge clk); #1 bus_b.tx_valid = 1'b0;
    check_frame("b6A", fb(7'h6A, 1'b1), NF, 1'b0);

    // 0x55 with valid/data scrambled mid-frame (four ones: odd parity 1)
    @(negedge clk);
    bus_b.tx_data = 7'h55; bus_b.tx_valid = 1'b1;
    @(posedge clk);
    check_frame("b55 noise", fb(7'h55, 1'b1), NF, 1'b1);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx_b !== 1'b1 || busy_b !== 1'b0 || bus_b.tx_ready !== 1'b1) bad++;
    end
    chk("b55 no extra frame (bad clocks)", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised UART transmitter. Successor to the fixed-pattern clock/TX test block.
- Accepts one data word per valid/ready handshake and serialises it LSB-first on tx as a start bit, DATA_BITS data bits, an optional parity bit and STOP_BITS stop bits.
- Sits between system logic (or a TX FIFO) and the board TX pin.
- Supports back-to-back frames with zero idle gap.

Parameters:
- CLK_FREQ, 12000000: input clock frequency in Hz.
- BAUD, 9600: line rate in bit/s. Derived localparam DIV = CLK_FREQ/BAUD (1250 at defaults). DIV >= 2 is required; elaboration fails otherwise.
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- PARITY_ODD, 0: parity sense (0 = even, 1 = odd). Used only when UART_TX_PARITY_EN is defined.

Ports:
- clk  input  1  system clock.
- nrst  input  1  synchronous, active-low reset.
- tx_data  input  DATA_BITS  word to send. Sampled only on handshake.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line, registered, idle high.
- busy  output  1  high while a frame is on the line.
- bit_tick  output  1  one-cycle pulse on the last clock of every bit period (debug/scope).

Behaviour:
- Reset (nrst=0 at posedge clk): tx=1, tx_ready=1, busy=0, bit_tick=0, state=IDLE, baud counter=0, bit index=0.
- Reset mid-frame aborts the frame. tx returns high on the cycle after the reset edge. No partial stop bit is sent.
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- Handshake: a word is accepted on a clk edge where tx_valid && tx_ready.
  - On accept, tx_data is latched into a shift register. tx_data and tx_valid are don't-care afterwards until tx_ready returns.
- tx_ready is high in IDLE and during the final clock of the last stop bit (bit_tick && state==STOP && stop index==STOP_BITS-1). It is low at all other times.
- Latency: tx drives 0 (start bit) on the cycle after acceptance.
- Every bit lasts exactly DIV clocks.
  - Baud counter runs 0..DIV-1 and wraps. bit_tick=1 when the count equals DIV-1.
  - The counter is reset to 0 on acceptance, so bit timing is phase-aligned to the frame start.
- Transitions, each on bit_tick:
  - START -> DATA.
  - DATA: shifts out bit 0 first. After DATA_BITS bits, goes to PARITY if enabled, else STOP.
  - PARITY -> STOP.
  - STOP: counts STOP_BITS stop bits, then goes to IDLE. If a new word is accepted on that same edge, it goes directly to START instead.
- Back-to-back: with tx_valid held high, frames abut. Frame period is exactly (1 + DATA_BITS + P + STOP_BITS) * DIV clocks, where P is 1 with parity and 0 without.
- busy is high from the cycle after acceptance until the final stop bit completes. It stays high across a back-to-back handoff.
- tx_valid asserted while tx_ready=0 has no effect; the word is neither accepted nor queued.
- Bit index counter width is $clog2(DATA_BITS+1). Baud counter width is $clog2(DIV). Both wrap only via explicit reload, never via overflow.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA. tx = ^data_latched ^ PARITY_ODD for one bit period.
- Undefined: no PARITY state, PARITY_ODD is ignored, and the frame is 1 + DATA_BITS + STOP_BITS bits long.

Decomposition:
- Package uart_pkg:
  - state typedef (IDLE, START, DATA, PARITY, STOP).
  - Function computing DIV and the counter width.
  - Line-level constants: LINE_IDLE=1, START_BIT=0.
- Sub-module uart_baud_gen:
  - Ports: clk, nrst, restart, bit_tick. Parameter DIV.
  - Free-running 0..DIV-1 counter, cleared by restart.
  - Reused by the future uart_rx.

Test Plan:
- Defaults, send 0x54 once: tx goes low 1 cycle after accept, then line bits 0,0,0,1,0,1,0,1,0,1, each exactly 1250 clks; tx_ready returns high on the last stop clock.
- tx_valid held high with words 0xA5 then 0x3C: second start bit begins exactly 12500 clks after the first; no idle-high gap; busy never deasserts between frames.
- UART_TX_PARITY_EN, PARITY_ODD=0, 0x54 (three ones): parity bit = 1; with PARITY_ODD=1 parity bit = 0; frame length 11*DIV.
- DATA_BITS=7, STOP_BITS=2, DIV=4: sending 0x7F gives 0,1,1,1,1,1,1,1,1,1 (1 start + 7 data + 2 stop), 40 clks total.
- nrst pulsed low for one cycle during the 4th data bit: tx=1, busy=0, tx_ready=1 the cycle after the reset edge; a new word sent afterwards transmits correctly.
- tx_valid toggled and tx_data changed mid-frame: transmitted bits match the word latched at acceptance; no extra frame is produced.
